field_gen: RTL

Parametrised lumber-collection cellular-automaton engine: a ROWS×COLS grid of open/tree/lumberyard cells, loaded row by row and advanced one full generation per clock for a programmed number of generations. It supersedes the fixed 50×50 free-running field. It adds a row-load port, start/abort control with a generation target, a done pulse, registered per-type counts, the resource value, and load-error detection. It sits between the puzzle-input loader and the result reporter.

---
 rtl/field_gen_if.sv | 41 ++++
 rtl/field_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/field_gen_if.sv
// Bundle between the puzzle-input loader / result reporter and field_gen.
// The loader side drives row loads and run control; field_gen reports state and results.
interface field_gen_if #(
  parameter int ROWS  = 50,
  parameter int COLS  = 50,
  parameter int GEN_W = 32,
  parameter int CNT_W = 12
) ();
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N  = ROWS * COLS;

  logic             load_en;
  logic [RW-1:0]    load_row;
  logic [COLS-1:0]  load_trees;
  logic [COLS-1:0]  load_lumber;
  logic             start;
  logic [GEN_W-1:0] gens;
  logic             abort;

  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic [N-1:0]     trees;
  logic [N-1:0]     lumberyards;
  logic [CNT_W-1:0] tree_count;
  logic [CNT_W-1:0] lumber_count;
  logic [2*CNT_W-1:0] resource;
  logic             load_err;

  modport slave (
    input  load_en, load_row, load_trees, load_lumber, start, gens, abort,
    output busy, done, gen_count, trees, lumberyards, tree_count, lumber_count,
           resource, load_err
  );

  modport master (
    output load_en, load_row, load_trees, load_lumber, start, gens, abort,
    input  busy, done, gen_count, trees, lumberyards, tree_count, lumber_count,
           resource, load_err
  );
endinterface

// File: rtl/field_gen.sv
// Lumber-collection cellular automaton: ROWS x COLS grid advanced one generation per
// clock for a programmed count, with row loading, abort, done pulse and registered counts.

module field_cell (
  input  logic       tree_i,
  input  logic       lum_i,
  input  logic [7:0] nb_tree_i,
  input  logic [7:0] nb_lum_i,
  output logic       tree_o,
  output logic       lum_o
);
  logic [3:0] nt, nl;

  always_comb begin
    nt     = '0;
    nl     = '0;
    tree_o = 1'b0;
    lum_o  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nt = nt + 4'(nb_tree_i[k]);
      nl = nl + 4'(nb_lum_i[k]);
    end
    if (lum_i) begin
      lum_o = (nl != 4'd0) && (nt != 4'd0);
    end else if (tree_i) begin
      lum_o  = (nl >= 4'd3);
      tree_o = ~lum_o;
    end else begin
      tree_o = (nt >= 4'd3);
    end
  end
endmodule

module field_gen #(
  parameter int ROWS  = 50,
  parameter int COLS  = 50,
  parameter int GEN_W = 32,
  parameter int CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  field_gen_if.slave  bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N  = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t             state_q;
  logic [N-1:0]       trees_q, lum_q;
  logic [GEN_W-1:0]   gen_q, tgt_q;
  logic [CNT_W-1:0]   tcnt_q, lcnt_q;
  logic               busy_q, done_q, err_q;

  logic [N-1:0]       tree_nx, lum_nx;
  logic [N-1:0]       trees_ld, lum_ld;
  logic [CNT_W-1:0]   tpop, lpop;
  logic [COLS-1:0]    bad_cols;
  logic               load_ok, bad_ld;
  logic [GEN_W-1:0]   gen_inc;

  // Zero border so edge cells see out-of-grid neighbours as open
  logic [ROWS+1:0][COLS+1:0] tpad, lpad;

  always_comb begin
    tpad = '0;
    lpad = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        tpad[r+1][c+1] = trees_q[r*COLS+c];
        lpad[r+1][c+1] = lum_q[r*COLS+c];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbt, nbl;
      assign nbt = {tpad[r][c],   tpad[r][c+1],   tpad[r][c+2],
                    tpad[r+1][c],                 tpad[r+1][c+2],
                    tpad[r+2][c], tpad[r+2][c+1], tpad[r+2][c+2]};
      assign nbl = {lpad[r][c],   lpad[r][c+1],   lpad[r][c+2],
                    lpad[r+1][c],                 lpad[r+1][c+2],
                    lpad[r+2][c], lpad[r+2][c+1], lpad[r+2][c+2]};
      field_cell u_cell (
        .tree_i    (trees_q[r*COLS+c]),
        .lum_i     (lum_q[r*COLS+c]),
        .nb_tree_i (nbt),
        .nb_lum_i  (nbl),
        .tree_o    (tree_nx[r*COLS+c]),
        .lum_o     (lum_nx[r*COLS+c])
      );
    end
  end

  // Row load; a column claiming both types is stored as open and flagged
  assign bad_cols = bus.load_trees & bus.load_lumber;
  assign load_ok  = bus.load_en && (32'(bus.load_row) < ROWS);
  assign bad_ld   = load_ok && (|bad_cols);

  always_comb begin
    trees_ld = trees_q;
    lum_ld   = lum_q;
    for (int r = 0; r < ROWS; r++) begin
      if (load_ok && (bus.load_row == RW'(r))) begin
        trees_ld[r*COLS +: COLS] = bus.load_trees  & ~bad_cols;
        lum_ld[r*COLS +: COLS]   = bus.load_lumber & ~bad_cols;
      end
    end
  end

  always_comb begin
    tpop = '0;
    lpop = '0;
    for (int i = 0; i < N; i++) begin
      tpop = tpop + CNT_W'(trees_q[i]);
      lpop = lpop + CNT_W'(lum_q[i]);
    end
  end

  assign gen_inc = gen_q + GEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      trees_q <= '0;
      lum_q   <= '0;
      gen_q   <= '0;
      tgt_q   <= '0;
      tcnt_q  <= '0;
      lcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tcnt_q <= tpop;
      lcnt_q <= lpop;
      case (state_q)
        S_IDLE: begin
          trees_q <= trees_ld;
          lum_q   <= lum_ld;
          if (bad_ld) err_q <= 1'b1;
          if (bus.start) begin
            gen_q   <= '0;
            tgt_q   <= bus.gens;
            err_q   <= bad_ld;
            busy_q  <= 1'b1;
            state_q <= (bus.gens != '0) ? S_RUN : S_FLUSH;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            trees_q <= tree_nx;
            lum_q   <= lum_nx;
            gen_q   <= gen_inc;
            if (gen_inc == tgt_q) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Counts sample the final grid at this edge, alongside done
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.gen_count    = gen_q;
  assign bus.trees        = trees_q;
  assign bus.lumberyards  = lum_q;
  assign bus.tree_count   = tcnt_q;
  assign bus.lumber_count = lcnt_q;
  assign bus.resource     = {{CNT_W{1'b0}}, tcnt_q} * {{CNT_W{1'b0}}, lcnt_q};
  assign bus.load_err     = err_q;
endmodule
